// File: rtl/lane_request_encoder.sv
// lane_request_encoder: latch per-lane request pulses and offer one lane index at a time on a valid/ready handshake
module lane_request_encoder #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int MIN_GAP     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_in,
  input  logic       code_ready,
  output logic       code_valid,
  output logic       code_bit_0,
  output logic       code_bit_1,
  output logic [3:0] pending,
  output logic       req_merged
);
  if (MIN_GAP < 0 || MIN_GAP > 15) begin : g_bad_gap
    $error("MIN_GAP must be in 0..15");
  end
  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;
  state_t     state_q, state_d;
  logic [1:0] code_q, code_d, ptr_q, ptr_d, start, sel, idx;
  logic [3:0] pending_q, pending_d, gap_q, gap_d, cand;
  logic       merged_q, merged_d, accept, found, load;
  always_comb begin
    accept    = (state_q == OFFER) & code_ready;
    // a request arriving on the lane being accepted is a fresh entry, so only the old entry is cleared
    cand      = (pending_q & ~(accept ? 4'b0001 << code_q : 4'b0000)) | req_in;
    ptr_d     = accept ? code_q + 2'd1 : ptr_q;
    start     = ROUND_ROBIN ? ptr_d : 2'd0;
    sel       = 2'd0;
    found     = 1'b0;
    idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (cand[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    // the last gap cycle already behaves as idle so exactly MIN_GAP cycles have valid low
    load      = found & ((state_q == IDLE) | ((state_q == GAP) & (gap_q <= 4'd1)) | (accept & (MIN_GAP == 0)));
    gap_d     = accept ? 4'(MIN_GAP) : ((state_q == GAP) && (gap_q != 4'd0)) ? gap_q - 4'd1 : gap_q;
    state_d   = load ? OFFER : accept ? ((MIN_GAP > 0) ? GAP : IDLE) :
                ((state_q == GAP) && (gap_q <= 4'd1)) ? IDLE : state_q;
    code_d    = load ? sel : code_q;
    pending_d = cand & ~(load ? 4'b0001 << sel : 4'b0000);
    merged_d  = |(req_in & pending_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= 2'd0;
      ptr_q     <= 2'd0;
      gap_q     <= 4'd0;
      pending_q <= 4'd0;
      merged_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      merged_q  <= merged_d;
    end
  end
  assign code_valid = (state_q == OFFER);
  assign code_bit_0 = code_q[1];
  assign code_bit_1 = code_q[0];
  assign pending    = pending_q;
  assign req_merged = merged_q;
endmodule

// File: tb/tb_lane_request_encoder.sv
// tb_lane_request_encoder: directed checks of three encoder configurations against an in-bench model
module tb_lane_request_encoder;
  logic clk = 1'b0, rst = 1'b1, code_ready = 1'b0;
  logic [3:0] req_in = 4'd0;
  logic [2:0] v, b0, b1, mo;
  logic [2:0][3:0] pd;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  lane_request_encoder #(.ROUND_ROBIN(1'b1), .MIN_GAP(0)) u_a (.clk(clk), .rst(rst), .req_in(req_in), .code_ready(code_ready),
    .code_valid(v[0]), .code_bit_0(b0[0]), .code_bit_1(b1[0]), .pending(pd[0]), .req_merged(mo[0]));
  lane_request_encoder #(.ROUND_ROBIN(1'b1), .MIN_GAP(2)) u_b (.clk(clk), .rst(rst), .req_in(req_in), .code_ready(code_ready),
    .code_valid(v[1]), .code_bit_0(b0[1]), .code_bit_1(b1[1]), .pending(pd[1]), .req_merged(mo[1]));
  lane_request_encoder #(.ROUND_ROBIN(1'b0), .MIN_GAP(0)) u_c (.clk(clk), .rst(rst), .req_in(req_in), .code_ready(code_ready),
    .code_valid(v[2]), .code_bit_0(b0[2]), .code_bit_1(b1[2]), .pending(pd[2]), .req_merged(mo[2]));
  typedef struct packed {
    logic [3:0] pend;
    logic       val;
    logic [1:0] code;
    logic [1:0] ptr;
    logic [3:0] gap;
    logic       mrg;
  } mst_t;
  mst_t m [3];
  localparam int RR [3] = '{1, 1, 0};
  localparam int MG [3] = '{0, 2, 0};
  function automatic mst_t mstep(mst_t s, int rr, int mg, logic [3:0] req, logic rdy);
    mst_t n = s;
    logic acc = s.val & rdy;
    logic [3:0] c = s.pend;
    logic ld;
    int st;
    n.mrg = |(req & s.pend);
    if (acc) begin
      c[s.code] = 1'b0;
      n.ptr = 2'((int'(s.code) + 1) % 4);
    end
    c = c | req;
    ld = s.val ? (acc && mg == 0) : (s.gap <= 1);
    if (acc) begin
      n.val = 1'b0;
      n.gap = 4'(mg);
    end else if (!s.val && s.gap > 0) n.gap = s.gap - 4'd1;
    if (ld) begin
      st = rr ? int'(n.ptr) : 0;
      for (int k = 0; k < 4; k++)
        if (!n.val && c[(st + k) % 4]) begin
          n.val = 1'b1;
          n.code = 2'((st + k) % 4);
          c[(st + k) % 4] = 1'b0;
        end
    end
    n.pend = c;
    return n;
  endfunction
  always @(posedge clk or posedge rst)
    for (int i = 0; i < 3; i++) m[i] <= rst ? '0 : mstep(m[i], RR[i], MG[i], req_in, code_ready);
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_valid[%0d]", i), 8'(v[i]), 8'(m[i].val));
      chk($sformatf("model_pending[%0d]", i), 8'(pd[i]), 8'(m[i].pend));
      chk($sformatf("model_merged[%0d]", i), 8'(mo[i]), 8'(m[i].mrg));
      if (m[i].val) chk($sformatf("model_code[%0d]", i), 8'({b0[i], b1[i]}), 8'(m[i].code));
    end
  function automatic logic [7:0] code(int i);
    return 8'({b0[i], b1[i]});
  endfunction
  task automatic drive(logic [3:0] r, logic rd);
    req_in = r;
    code_ready = rd;
    @(negedge clk);
  endtask
  task automatic do_rst;
    rst = 1'b1;
    req_in = 4'd0;
    code_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  int seen3_rr, seen3_fix;
  initial begin
    #1;
    chk("reset_valid", 8'(v), 8'd0);
    chk("reset_pending_a", 8'(pd[0]), 8'd0);
    chk("reset_code_a", code(0), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0100, 1'b1);
    chk("t1_valid", 8'(v[0]), 8'd1);
    chk("t1_bit0", 8'(b0[0]), 8'd1);
    chk("t1_bit1", 8'(b1[0]), 8'd0);
    drive(4'b0000, 1'b1);
    chk("t1_valid_after", 8'(v[0]), 8'd0);
    chk("t1_pending_after", 8'(pd[0]), 8'd0);
    do_rst;
    drive(4'b1111, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_valid_%0d", k), 8'(v[0]), 8'd1);
      chk($sformatf("t2_code_%0d", k), code(0), 8'(k));
      drive(4'b0000, 1'b1);
    end
    chk("t2_valid_end", 8'(v[0]), 8'd0);
    do_rst;
    drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b0);
    chk("t3_code_hold0", code(0), 8'd1);
    drive(4'b0001, 1'b0);
    chk("t3_code_hold1", code(0), 8'd1);
    chk("t3_pending", 8'(pd[0]), 8'b0001);
    drive(4'b0001, 1'b0);
    chk("t3_merged", 8'(mo[0]), 8'd1);
    drive(4'b0000, 1'b0);
    chk("t3_merged_clear", 8'(mo[0]), 8'd0);
    chk("t3_code_hold2", code(0), 8'd1);
    drive(4'b0000, 1'b1);
    chk("t3_next_valid", 8'(v[0]), 8'd1);
    chk("t3_next_lane0", code(0), 8'd0);
    drive(4'b0000, 1'b1);
    chk("t3_done", 8'(v[0]), 8'd0);
    do_rst;
    drive(4'b0011, 1'b1);
    chk("t4_lane0", {7'd0, v[1]} + code(1), 8'd1);
    drive(4'b0000, 1'b1);
    chk("t4_gap1", 8'(v[1]), 8'd0);
    drive(4'b0000, 1'b1);
    chk("t4_gap2", 8'(v[1]), 8'd0);
    drive(4'b0000, 1'b1);
    chk("t4_lane1_valid", 8'(v[1]), 8'd1);
    chk("t4_lane1_code", code(1), 8'd1);
    drive(4'b0000, 1'b1);
    chk("t4_end", 8'(v[1]), 8'd0);
    do_rst;
    drive(4'b0110, 1'b0);
    chk("t5_pre_valid", 8'(v[0]), 8'd1);
    chk("t5_pre_pending", 8'(pd[0]), 8'b0100);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", 8'(v), 8'd0);
    chk("t5_async_code", code(0), 8'd0);
    chk("t5_async_pending", 8'(pd[0]), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0000, 1'b0);
    chk("t5_idle_after", 8'(v[0]), 8'd0);
    do_rst;
    seen3_rr = 0;
    seen3_fix = 0;
    drive(4'b1001, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (v[0] && code(0) == 8'd3 && k < 4) seen3_rr = 1;
      if (v[2] && code(2) == 8'd3) seen3_fix = 1;
      drive(4'b0001, 1'b1);
    end
    chk("t6_rr_serves_lane3", 8'(seen3_rr), 8'd1);
    chk("t6_fixed_starves_lane3", 8'(seen3_fix), 8'd0);
    chk("t6_fixed_lane3_pending", 8'(pd[2]), 8'b1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
